mem_access_stage: RTL

- MEM stage of the 5-stage RV32 pipeline. Sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register.
- Turns the registered load/store control into a request/acknowledge transaction toward the data-side AXI master wrapper.
- Holds the pipeline with a stall until the access completes, then presents aligned and sign-extended load data to writeback.

---
 rtl/mem_access_stage_if.sv | 31 +++
 rtl/mem_access_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the
// data-side AXI master wrapper.
//   dm_req   : request, held high until dm_ack
//   dm_we    : 1 = write, 0 = read
//   dm_addr  : byte address
//   dm_wstrb : byte write strobes (all zero on reads)
//   dm_wdata : write data
//   dm_ack   : transfer complete (read data valid / write response seen)
//   dm_rdata : read data, valid with dm_ack
// master = pipeline side (mem_access_stage), slave = bus wrapper side.
interface mem_access_stage_if #(
  parameter int DATA_W = 32
);
  logic              dm_req;
  logic              dm_we;
  logic [DATA_W-1:0] dm_addr;
  logic [3:0]        dm_wstrb;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage RV32 pipeline.
// Converts the registered load/store control from EX/MEM into one
// request/acknowledge transaction on the data-memory bus, stalls the front
// of the pipeline until the transfer completes, and hands aligned,
// sign-extended load data to MEM/WB.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   result_in        : ALU result, used as the memory address
//   data2_in         : store data
//   rd_in, wb_*_in   : writeback control, passed straight through
//   mem_memread_in   : load,  mem_memwrite_in : store (store wins if both)
//   ls_word_in       : 1 = word access, 0 = byte access
//   dm               : data-memory bus (master side)
//   stall            : freezes PC, IF/ID, ID/EX and EX/MEM
//   mem_rdata_out    : extended load data to MEM/WB
//   result_out, rd_out, wb_*_out : pass-throughs
module mem_access_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] data2_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              wb_memtoreg_in,
  input  logic              wb_regwrite_in,
  input  logic              mem_memread_in,
  input  logic              mem_memwrite_in,
  input  logic              ls_word_in,
  mem_access_stage_if.master dm,
  output logic              stall,
  output logic [DATA_W-1:0] mem_rdata_out,
  output logic [DATA_W-1:0] result_out,
  output logic [REG_AW-1:0] rd_out,
  output logic              wb_memtoreg_out,
  output logic              wb_regwrite_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              word_q, word_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  logic              access;
  logic [DATA_W-1:0] lane_shifted;
  logic [DATA_W-1:0] load_ext;

  assign access = mem_memread_in | mem_memwrite_in;

  // Byte loads pick the lane addressed by the latched low address bits.
  assign lane_shifted = dm.dm_rdata >> {addr_q[1:0], 3'b000};
  assign load_ext     = word_q ? dm.dm_rdata
                               : {{(DATA_W-8){lane_shifted[7]}}, lane_shifted[7:0]};

  // State and access-field registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      word_q      <= 1'b0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      word_q      <= word_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Next-state and latch logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    word_d      = word_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    mem_rdata_d = mem_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (access) begin
          state_d = BUSY;
          we_d    = mem_memwrite_in;
          word_d  = ls_word_in;
          if (ls_word_in) begin
            addr_d  = {result_in[DATA_W-1:2], 2'b00};
            wstrb_d = 4'b1111;
            wdata_d = data2_in;
          end else begin
            addr_d  = result_in;
            wstrb_d = 4'b0001 << result_in[1:0];
            wdata_d = {(DATA_W/8){data2_in[7:0]}};
          end
          // Reads never assert byte strobes.
          if (!mem_memwrite_in) begin
            wstrb_d = 4'b0000;
          end
        end
      end
      BUSY: begin
        if (dm.dm_ack) begin
          state_d = DONE;
          if (!we_q) begin
            mem_rdata_d = load_ext;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. Stall is qualified by rst so that a reset mid-access releases
  // the pipeline in the same cycle even while EX/MEM still shows an access.
  always_comb begin
    stall     = 1'b0;
    dm.dm_req = 1'b0;
    unique case (state_q)
      IDLE:    stall = access;
      BUSY: begin
        stall     = 1'b1;
        dm.dm_req = 1'b1;
      end
      DONE:    stall = 1'b0;
      default: stall = 1'b0;
    endcase
    if (rst) begin
      stall = 1'b0;
    end
  end

  assign dm.dm_we    = we_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_wstrb = wstrb_q;
  assign dm.dm_wdata = wdata_q;

  assign mem_rdata_out   = mem_rdata_q;
  assign result_out      = result_in;
  assign rd_out          = rd_in;
  assign wb_memtoreg_out = wb_memtoreg_in;
  assign wb_regwrite_out = wb_regwrite_in;

endmodule
